// File: rtl/ir_queue.sv
// Instruction register with DEPTH-entry prefetch queue; head is combinational, bus/ALU copies register 1 edge after load.
// Backpressure: push accepted unless full (or full with simultaneous pop); rejected push/pop sets sticky err.
module ir_queue #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH+1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] im,
   input  logic             wr,
   input  logic             adv,
   input  logic             flush,
   input  logic             ldbus,
   input  logic             ldalu,
   output logic [WIDTH-1:0] bout,
   output logic             bout_en,
   output logic [WIDTH-1:0] alu,
   output logic [WIDTH-1:0] cu,
   output logic             cu_valid,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count,
   output logic             err
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rp;
   logic [AW-1:0]    wp;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] head;
   logic             push_ok;
   logic             pop_ok;
   logic             err_set;

   assign head     = mem[rp];
   assign empty    = (cnt == '0);
   assign full     = (cnt == CW'(DEPTH));
   assign count    = cnt;
   assign cu_valid = ~empty;
   assign cu       = empty ? '0 : head;

   // A pop frees the slot the same edge, so a full queue still takes a push alongside adv.
   assign push_ok = wr & (~full | adv);
   assign pop_ok  = adv & ~empty;
   assign err_set = (wr & full & ~adv) | (adv & empty & ~wr);

   always_ff @(posedge clk) begin
      if (rst_n && !flush && push_ok) begin
         mem[wp] <= im;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rp  <= '0;
         wp  <= '0;
         cnt <= '0;
         err <= 1'b0;
      end else if (flush) begin
         rp  <= '0;
         wp  <= '0;
         cnt <= '0;
         err <= 1'b0;
      end else begin
         if (push_ok) begin
            wp <= wp + 1'b1;
         end
         if (pop_ok) begin
            rp <= rp + 1'b1;
         end
         if (push_ok && !pop_ok) begin
            cnt <= cnt + 1'b1;
         end else if (pop_ok && !push_ok) begin
            cnt <= cnt - 1'b1;
         end
         if (err_set) begin
            err <= 1'b1;
         end
      end
   end

   // Loads see the pre-pop, pre-flush head; the bus load wins over the ALU load.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bout    <= '0;
         bout_en <= 1'b0;
         alu     <= '0;
      end else begin
         bout_en <= 1'b0;
         if (ldbus) begin
            if (!empty) begin
               bout    <= head;
               bout_en <= 1'b1;
            end
         end else if (ldalu && !empty) begin
            alu <= head;
         end
      end
   end

endmodule

// File: doc/ir_queue.md
# ir_queue

Parametrised instruction register with a DEPTH-entry prefetch queue. Instruction words from the instruction-memory port are queued. The oldest word is presented continuously to the control unit, and is copied on request to the bus output or the ALU-operand output. The queue decouples instruction fetch from execution: fetch can run up to DEPTH words ahead, and the control unit retires words with `adv` or discards them with `flush` on a branch.

## Interface
- `WIDTH`, default 16: instruction word width in bits.
- `DEPTH`, default 4: number of queue entries. Must be a power of two, ≥2.
- `CW`, default `$clog2(DEPTH+1)`: width of `count`. Derived; do not override.

Ports:
- `clk` input 1: the only clock. All state updates on the rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `im` input WIDTH: instruction word from instruction memory.
- `wr` input 1: push `im` into the queue.
- `adv` input 1: retire the head word (pop).
- `flush` input 1: discard all queued words.
- `ldbus` input 1: copy the head word to `bout`.
- `ldalu` input 1: copy the head word to `alu`.
- `bout` output WIDTH: registered bus data.
- `bout_en` output 1: `bout` is valid this cycle; the bus arbiter drives the shared bus only when this is high.
- `alu` output WIDTH: registered ALU operand; holds its value between loads.
- `cu` output WIDTH: head word, combinational from queue state; 0 when empty.
- `cu_valid` output 1: queue not empty.
- `full` output 1: count == DEPTH.
- `empty` output 1: count == 0.
- `count` output CW: number of occupied entries.
- `err` output 1: sticky protocol-error flag.

## Operation
- Storage: DEPTH×WIDTH array with read pointer `rp` and write pointer `wp`, each `log2(DEPTH)` bits wide. Both wrap modulo DEPTH with no special-case logic. `count` is tracked separately.
- Accepted push: `wr & (~full | adv)`. The word is written at `wp`, and `wp` increments.
- Accepted pop: `adv & ~empty`. `rp` increments.
- Push and pop in the same cycle: both are accepted and `count` is unchanged, including when full.
- Push and pop on an empty queue in the same cycle: the push is accepted, the pop is rejected, and count becomes 1.
- Rejected push: `wr & full & ~adv`. Storage is unchanged and `err` is set.
- Rejected pop: `adv & empty & ~(wr)`. `err` is set. The case where `wr` is also high is covered by the empty-queue rule above and does not set `err`.
- `flush` has priority over `wr` and `adv` in the same cycle:
  - `rp`, `wp` and `count` go to 0.
  - The push is discarded.
  - `err` is cleared.
- `ldbus`, sampled at the rising edge:
  - If `~empty`: `bout <= head`, `bout_en <= 1`.
  - Otherwise: `bout_en <= 0` and `bout` holds its value.
- `ldalu` is honoured only when `ldbus` is low, because the bus load has priority:
  - If `~empty`: `alu <= head`.
  - Otherwise `alu` holds.
- `ldbus` and `ldalu` sample the head before any pop in the same cycle, so `ldbus & adv` delivers the retiring word.
- `flush` in the same cycle as `ldbus` or `ldalu`: the load uses the pre-flush head.
- `err` clears only on `flush` or reset.

## Timing
- Reset (`rst_n` low at a rising edge) sets:
  - `rp`, `wp`, `count` = 0; `empty` = 1, `full` = 0, `cu_valid` = 0, `cu` = 0.
  - `bout` = 0, `bout_en` = 0, `alu` = 0, `err` = 0.
  - Storage contents are don't-care.
- Reset has priority over every other input. Reset asserted mid-stream discards queued words the same way `flush` does.
- Push-to-head latency: a word pushed into an empty queue at edge N appears on `cu`, with `cu_valid` = 1, after edge N.
- `cu`, `cu_valid`, `full`, `empty` and `count` all reflect state after the most recent edge. No input combinationally affects them.
- `bout`/`bout_en` and `alu` update one edge after `ldbus`/`ldalu` is sampled. `bout_en` is a one-cycle pulse per sampled `ldbus`.
- Sustained throughput: one push and one pop per cycle.

## Test plan
- Reset then idle: drive `rst_n` = 0 for 2 cycles, then release -> all outputs at their reset values; `count` = 0, `cu` = 0x0000.
- Fill and overflow (DEPTH = 4): push 0x1111, 0x2222, 0x3333, 0x4444 -> `full` = 1, `cu` = 0x1111. Push 0x5555 -> ignored, `err` = 1. Then 4 pops -> `cu` sequence 0x2222, 0x3333, 0x4444, 0 and `empty` = 1.
- Wrap-around: 10 consecutive cycles with `wr` = `adv` = 1 and incrementing data 0xA000+i, after one priming push -> `count` stays 1, every word retires in order, `err` = 0.
- Full push+pop: with the queue full, assert `wr` (0xBEEF) and `adv` together -> `count` stays 4, `err` = 0, 0xBEEF retires last.
- Load priority: head 0x1234, `ldbus` = `ldalu` = 1 -> next cycle `bout` = 0x1234, `bout_en` = 1, `alu` unchanged. Then `ldalu` alone -> `alu` = 0x1234, `bout_en` = 0.
- Flush and underflow: 3 words queued, `adv` on an empty queue to set `err`, then `flush` together with `wr` (0x9999) -> `count` = 0, `err` = 0, 0x9999 never appears on `cu`.
